// File: rtl/alu_issue_ctrl_pkg.sv
// Shared ALU control encodings: FunctC codes, ALUOp selectors, R-type funct values
// and the issue FSM state type.
package alu_issue_ctrl_pkg;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_NOR = 4'b0011;
    localparam logic [3:0] ALU_MUL = 4'b1010;
    localparam logic [3:0] ALU_DIV = 4'b1111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_OR    = 2'b11;

    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_NOR  = 6'b100111;
    localparam logic [5:0] FN_MUL  = 6'b011000;
    localparam logic [5:0] FN_DIV  = 6'b011010;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StResp
    } state_t;

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Request, ALU-drive and response signals of the ALU issue unit.
// slave is the issue unit's view; master is the decode stage / ALU / consumer view.
interface alu_issue_ctrl_if;

    logic        req_valid;
    logic        req_ready;
    logic [1:0]  alu_op;
    logic [5:0]  funct;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic [3:0]  FunctC;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] ALUOut;
    logic        Zero;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] result;
    logic        result_zero;
    logic        illegal;

    modport slave (
        input  req_valid, alu_op, funct, a_in, b_in, ALUOut, Zero, rsp_ready,
        output req_ready, FunctC, A, B, rsp_valid, result, result_zero, illegal
    );

    modport master (
        output req_valid, alu_op, funct, a_in, b_in, ALUOut, Zero, rsp_ready,
        input  req_ready, FunctC, A, B, rsp_valid, result, result_zero, illegal
    );

endinterface

// File: rtl/alu_issue_ctrl_encode.sv
// Combinational {alu_op, funct} -> {FunctC, is_muldiv, illegal} encoder.
module alu_func_encode
    import alu_issue_ctrl_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [5:0] funct,
    output logic [3:0] functc,
    output logic       is_muldiv,
    output logic       illegal
);

    always_comb begin
        functc    = ALU_ADD;
        is_muldiv = 1'b0;
        illegal   = 1'b0;
        unique case (alu_op)
            ALUOP_ADD: functc = ALU_ADD;
            ALUOP_SUB: functc = ALU_SUB;
            ALUOP_OR:  functc = ALU_OR;
            ALUOP_RTYPE: begin
                case (funct)
                    FN_ADD, FN_ADDU: functc = ALU_ADD;
                    FN_SUB, FN_SUBU: functc = ALU_SUB;
                    FN_AND:          functc = ALU_AND;
                    FN_OR:           functc = ALU_OR;
                    FN_NOR:          functc = ALU_NOR;
                    FN_MUL: begin
                        functc    = ALU_MUL;
                        is_muldiv = 1'b1;
                    end
                    FN_DIV: begin
                        functc    = ALU_DIV;
                        is_muldiv = 1'b1;
                    end
                    // functc stays at a mapped code so the ALU default is never selected
                    default:         illegal = 1'b1;
                endcase
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// ALU issue unit: latches FunctC/A/B, holds them for a per-op settle time,
// then captures ALUOut/Zero and returns them over a valid/ready response.
module alu_issue_ctrl
    import alu_issue_ctrl_pkg::*;
#(
    parameter int unsigned SIMPLE_LAT = 1,
    parameter int unsigned MULDIV_LAT = 4
) (
    input logic              clk,
    input logic              rst,
    alu_issue_ctrl_if.slave  bus
);

    localparam int unsigned MaxLat = (SIMPLE_LAT > MULDIV_LAT) ? SIMPLE_LAT : MULDIV_LAT;
    localparam int unsigned CntW   = (MaxLat > 1) ? $clog2(MaxLat) : 1;
    localparam logic [CntW-1:0] SimpleLoad = CntW'(SIMPLE_LAT - 1);
    localparam logic [CntW-1:0] MulDivLoad = CntW'(MULDIV_LAT - 1);

    state_t            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [3:0]        functc_q, functc_d;
    logic [31:0]       a_q, a_d;
    logic [31:0]       b_q, b_d;
    logic [31:0]       result_q, result_d;
    logic              zero_q, zero_d;
    logic              illegal_q, illegal_d;

    logic [3:0]        dec_functc;
    logic              dec_muldiv;
    logic              dec_illegal;

    alu_func_encode u_encode (
        .alu_op    (bus.alu_op),
        .funct     (bus.funct),
        .functc    (dec_functc),
        .is_muldiv (dec_muldiv),
        .illegal   (dec_illegal)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        functc_d  = functc_q;
        a_d       = a_q;
        b_d       = b_q;
        result_d  = result_q;
        zero_d    = zero_q;
        illegal_d = illegal_q;
        unique case (state_q)
            StIdle: begin
                if (bus.req_valid) begin
                    if (dec_illegal) begin
                        // ALU inputs untouched so an illegal op never toggles them
                        state_d   = StResp;
                        illegal_d = 1'b1;
                        result_d  = '0;
                        zero_d    = 1'b0;
                    end else begin
                        state_d  = StIssue;
                        functc_d = dec_functc;
                        a_d      = bus.a_in;
                        b_d      = bus.b_in;
                        cnt_d    = dec_muldiv ? MulDivLoad : SimpleLoad;
                    end
                end
            end
            StIssue: begin
                if (cnt_q == '0) begin
                    state_d   = StResp;
                    result_d  = bus.ALUOut;
                    zero_d    = bus.Zero;
                    illegal_d = 1'b0;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StResp: begin
                if (bus.rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            functc_q  <= ALU_ADD;
            a_q       <= '0;
            b_q       <= '0;
            result_q  <= '0;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            functc_q  <= functc_d;
            a_q       <= a_d;
            b_q       <= b_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            illegal_q <= illegal_d;
        end
    end

    assign bus.req_ready   = (state_q == StIdle);
    assign bus.rsp_valid   = (state_q == StResp);
    assign bus.FunctC      = functc_q;
    assign bus.A           = a_q;
    assign bus.B           = b_q;
    assign bus.result      = result_q;
    assign bus.result_zero = zero_q;
    assign bus.illegal     = illegal_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Table-driven bench for alu_issue_ctrl with a behavioural ALU and an expected-response queue.
module tb_alu_issue_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;

    alu_issue_ctrl_if bus ();

    alu_issue_ctrl #(
        .SIMPLE_LAT (1),
        .MULDIV_LAT (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [31:0] alu_res;
    always_comb begin
        case (bus.FunctC)
            4'b0010: alu_res = bus.A + bus.B;
            4'b0110: alu_res = bus.A - bus.B;
            4'b0000: alu_res = bus.A & bus.B;
            4'b0001: alu_res = bus.A | bus.B;
            4'b0011: alu_res = ~(bus.A | bus.B);
            4'b1010: alu_res = bus.A * bus.B;
            4'b1111: alu_res = (bus.B == 32'd0) ? 32'd0 : bus.A / bus.B;
            default: alu_res = 32'hdead_beef;
        endcase
    end
    assign bus.ALUOut = alu_res;
    assign bus.Zero   = (alu_res == 32'd0);

    typedef struct {
        logic [1:0]  op;
        logic [5:0]  fn;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  fc;
        logic [31:0] res;
        logic        z;
        logic        ill;
        int          lat;
        int          hold;
    } vec_t;

    typedef struct {
        logic [3:0]  fc;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        z;
        logic        ill;
        int          lat;
    } exp_t;

    vec_t tbl[15];
    exp_t sb[$];

    int total = 0;
    int bad   = 0;

    logic [3:0]  last_fc = 4'b0010;
    logic [31:0] last_a  = 32'd0;
    logic [31:0] last_b  = 32'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " req_ready"},   32'(bus.req_ready),   32'd1);
        check({tag, " FunctC"},      32'(bus.FunctC),      32'h2);
        check({tag, " A"},           bus.A,                32'd0);
        check({tag, " B"},           bus.B,                32'd0);
        check({tag, " rsp_valid"},   32'(bus.rsp_valid),   32'd0);
        check({tag, " result"},      bus.result,           32'd0);
        check({tag, " result_zero"}, 32'(bus.result_zero), 32'd0);
        check({tag, " illegal"},     32'(bus.illegal),     32'd0);
    endtask

    task automatic run_op(input vec_t v, input int idx);
        exp_t e;
        exp_t got_e;
        int   cycles;
        bit   got;
        bit   held_ok;
        bit   bp_ok;
        logic [31:0] res_snap;

        e.fc  = v.ill ? last_fc : v.fc;
        e.a   = v.ill ? last_a  : v.a;
        e.b   = v.ill ? last_b  : v.b;
        e.res = v.res;
        e.z   = v.z;
        e.ill = v.ill;
        e.lat = v.lat;

        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.alu_op    = v.op;
        bus.funct     = v.fn;
        bus.a_in      = v.a;
        bus.b_in      = v.b;
        sb.push_back(e);
        if (!v.ill) begin
            last_fc = v.fc;
            last_a  = v.a;
            last_b  = v.b;
        end

        cycles  = 0;
        got     = 1'b0;
        held_ok = 1'b1;
        while (cycles < 20 && !got) begin
            @(posedge clk);
            cycles++;
            #1;
            if (cycles == 1) bus.req_valid = 1'b0;
            if (bus.rsp_valid) begin
                got = 1'b1;
            end else if (!bus.req_ready) begin
                if (bus.FunctC !== e.fc || bus.A !== e.a || bus.B !== e.b) held_ok = 1'b0;
            end
        end

        total++;
        if (!got) begin
            bad++;
            $display("FAIL timeout vec%0d: no rsp_valid after %0d cycles", idx, cycles);
            void'(sb.pop_front());
            return;
        end

        got_e = sb.pop_front();
        check($sformatf("vec%0d latency", idx),     32'(cycles),          32'(got_e.lat));
        check($sformatf("vec%0d held", idx),        32'(held_ok),         32'd1);
        check($sformatf("vec%0d result", idx),      bus.result,           got_e.res);
        check($sformatf("vec%0d result_zero", idx), 32'(bus.result_zero), 32'(got_e.z));
        check($sformatf("vec%0d illegal", idx),     32'(bus.illegal),     32'(got_e.ill));
        check($sformatf("vec%0d FunctC", idx),      32'(bus.FunctC),      32'(got_e.fc));
        check($sformatf("vec%0d A", idx),           bus.A,                got_e.a);
        check($sformatf("vec%0d B", idx),           bus.B,                got_e.b);

        // Backpressure: a competing request while busy must be ignored
        if (v.hold > 0) begin
            bp_ok    = 1'b1;
            res_snap = bus.result;
            bus.req_valid = 1'b1;
            bus.alu_op    = 2'b00;
            bus.funct     = 6'd0;
            bus.a_in      = 32'd99;
            bus.b_in      = 32'd1;
            for (int i = 0; i < v.hold; i++) begin
                @(posedge clk);
                #1;
                if (bus.result !== res_snap || bus.req_ready !== 1'b0 ||
                    bus.rsp_valid !== 1'b1 || bus.A !== got_e.a) bp_ok = 1'b0;
            end
            bus.req_valid = 1'b0;
            check($sformatf("vec%0d backpressure stable", idx), 32'(bp_ok), 32'd1);
        end

        @(negedge clk);
        check($sformatf("vec%0d req_ready in rsp", idx), 32'(bus.req_ready), 32'd0);
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        check($sformatf("vec%0d rsp_valid after hs", idx), 32'(bus.rsp_valid), 32'd0);
        check($sformatf("vec%0d req_ready after hs", idx), 32'(bus.req_ready), 32'd1);
        check($sformatf("vec%0d A after hs", idx),         bus.A,              got_e.a);
    endtask

    initial begin
        bit no_rsp;

        tbl[0]  = '{2'b00, 6'd0,      32'd5,         32'd7,         4'b0010, 32'd12,        1'b0, 1'b0, 2, 0};
        tbl[1]  = '{2'b01, 6'd0,      32'h1234,      32'h1234,      4'b0110, 32'd0,         1'b1, 1'b0, 2, 0};
        tbl[2]  = '{2'b11, 6'd0,      32'hf0,        32'h0f,        4'b0001, 32'hff,        1'b0, 1'b0, 2, 0};
        tbl[3]  = '{2'b10, 6'b100000, 32'hffff_ffff, 32'd1,         4'b0010, 32'd0,         1'b1, 1'b0, 2, 0};
        tbl[4]  = '{2'b10, 6'b100001, 32'd10,        32'd20,        4'b0010, 32'd30,        1'b0, 1'b0, 2, 0};
        tbl[5]  = '{2'b10, 6'b100010, 32'd50,        32'd8,         4'b0110, 32'd42,        1'b0, 1'b0, 2, 0};
        tbl[6]  = '{2'b10, 6'b100011, 32'd3,         32'd5,         4'b0110, 32'hffff_fffe, 1'b0, 1'b0, 2, 0};
        tbl[7]  = '{2'b10, 6'b100100, 32'hff00_ff00, 32'h0ff0_0ff0, 4'b0000, 32'h0f00_0f00, 1'b0, 1'b0, 2, 0};
        tbl[8]  = '{2'b10, 6'b100101, 32'ha0,        32'h05,        4'b0001, 32'ha5,        1'b0, 1'b0, 2, 0};
        tbl[9]  = '{2'b10, 6'b100111, 32'hffff_0000, 32'h0000_ff00, 4'b0011, 32'h0000_00ff, 1'b0, 1'b0, 2, 0};
        tbl[10] = '{2'b10, 6'b011000, 32'd300,       32'd200,       4'b1010, 32'd60000,     1'b0, 1'b0, 5, 0};
        tbl[11] = '{2'b10, 6'b011010, 32'd100,       32'd7,         4'b1111, 32'd14,        1'b0, 1'b0, 5, 5};
        tbl[12] = '{2'b10, 6'b101010, 32'd1,         32'd2,         4'b0000, 32'd0,         1'b0, 1'b1, 1, 0};
        tbl[13] = '{2'b10, 6'b100110, 32'd3,         32'd4,         4'b0000, 32'd0,         1'b0, 1'b1, 1, 0};
        tbl[14] = '{2'b00, 6'd0,      32'd0,         32'd0,         4'b0010, 32'd0,         1'b1, 1'b0, 2, 0};

        bus.req_valid = 1'b0;
        bus.alu_op    = 2'b00;
        bus.funct     = 6'd0;
        bus.a_in      = 32'd0;
        bus.b_in      = 32'd0;
        bus.rsp_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("reset");
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 15; i++) begin
            run_op(tbl[i], i);
        end

        // Async reset in the middle of a divide: op dropped, no response
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.alu_op    = 2'b10;
        bus.funct     = 6'b011010;
        bus.a_in      = 32'd77;
        bus.b_in      = 32'd3;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        check("div accepted", 32'(bus.req_ready), 32'd0);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_reset_vals("midreset");
        @(negedge clk);
        rst = 1'b0;
        last_fc = 4'b0010;
        last_a  = 32'd0;
        last_b  = 32'd0;
        no_rsp  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (bus.rsp_valid !== 1'b0) no_rsp = 1'b0;
        end
        check("no rsp after reset", 32'(no_rsp), 32'd1);

        run_op(tbl[0], 100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
